// File: rtl/alu_pkg.sv
// Shared types for the shared-ALU arbiter: ALU opcodes and arbiter FSM states.
// Imported by alu and alu_arbiter.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD,
    SUB,
    LEFT_SHIFT,
    RIGHT_SHIFT_ARITHMETIC,
    RIGHT_SHIFT_LOGIC,
    AND,
    OR,
    XOR,
    EQUAL
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU, WORD_SIZE wide, results truncated, no carry out.
// Ports: a, b operands; op opcode; result (0 for undefined opcodes).
module alu
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  opcode_t              op,
  output logic [WORD_SIZE-1:0] result
);

  always_comb begin
    result = '0;
    unique case (op)
      ADD:                    result = a + b;
      SUB:                    result = a - b;
      LEFT_SHIFT:             result = a << b;
      RIGHT_SHIFT_ARITHMETIC: result = WORD_SIZE'($signed(a) >>> b);
      RIGHT_SHIFT_LOGIC:      result = a >> b;
      AND:                    result = a & b;
      OR:                     result = a | b;
      XOR:                    result = a ^ b;
      EQUAL:                  result = WORD_SIZE'(a == b);
      default:                result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ valid/ready requesters.
// Ports: clk, rst (async high); req_valid/ready/a/b/op per requester;
// rsp_valid/ready/data/id response channel; busy while not IDLE.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int WORD_SIZE = 16,
  parameter  int NUM_REQ   = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][WORD_SIZE-1:0] req_a,
  input  logic [NUM_REQ-1:0][WORD_SIZE-1:0] req_b,
  input  opcode_t [NUM_REQ-1:0]             req_op,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [WORD_SIZE-1:0]              rsp_data,
  output logic [ID_W-1:0]                   rsp_id,
  output logic                              busy
);

  state_t              state;
  state_t              state_nx;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     grant;
  logic                accept;
  logic [WORD_SIZE-1:0] lat_a;
  logic [WORD_SIZE-1:0] lat_b;
  opcode_t             lat_op;
  logic [ID_W-1:0]     lat_id;
  logic [WORD_SIZE-1:0] alu_out;

  // First valid index strictly after last, wrapping modulo NUM_REQ.
  function automatic logic [ID_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] v,
    input logic [ID_W-1:0]    last
  );
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && v[ID_W'(idx)]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    accept    = 1'b0;
    grant     = rr_pick(req_valid, last_grant);
    unique case (state)
      IDLE: begin
        // rst gate keeps req_ready low while reset is held.
        if (|req_valid && !rst) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_nx         = EXEC;
        end
      end
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= ADD;
      lat_id     <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
    end else begin
      if (accept) begin
        lat_a      <= req_a[grant];
        lat_b      <= req_b[grant];
        lat_op     <= req_op[grant];
        lat_id     <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_out;
        rsp_id    <= lat_id;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

  alu #(
    .WORD_SIZE(WORD_SIZE)
  ) u_alu (
    .a     (lat_a),
    .b     (lat_b),
    .op    (lat_op),
    .result(alu_out)
  );

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational alu instance among NUM_REQ requesters using round-robin arbitration.
- Each requester presents operands and an opcode through a valid/ready handshake.
- The granted operation is latched, executed, and returned on a single response channel tagged with the requester id.
- Sits between the OrgaSmall control units/ports and the shared ALU datapath.

Parameters:
- WORD_SIZE, 16, operand/result width; passed to the alu sub-module.
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the response id (derived localparam, not overridable).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_a  input  NUM_REQ x WORD_SIZE  packed operand A per requester.
- req_b  input  NUM_REQ x WORD_SIZE  packed operand B per requester.
- req_op  input  NUM_REQ x opcode_t  packed opcode per requester.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  WORD_SIZE  ALU result.
- rsp_id  output  ID_W  index of the requester that owns rsp_data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: state=IDLE; req_ready=0; rsp_valid=0; rsp_data=0; rsp_id=0; busy=0; last_grant=NUM_REQ-1, so requester 0 wins first. Reset mid-operation drops the in-flight transaction silently.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, grant the first valid index searching upward from last_grant+1, with wrap-around modulo NUM_REQ.
  - req_ready[grant]=1 combinationally in the same cycle; all other req_ready bits=0.
  - On the edge: latch a, b, op, id into operand registers; last_grant<=grant; go to EXEC.
  - If no req_valid is high, stay in IDLE.
- EXEC:
  - The alu is driven from the latched registers only.
  - On the edge: rsp_data<=alu out, rsp_id<=latched id, rsp_valid<=1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_data and rsp_id stable until rsp_ready=1.
  - On the handshake edge: rsp_valid<=0; go to IDLE.
  - Back-pressure may last indefinitely.
- req_ready is 0 in EXEC and RESP. A new grant occurs no earlier than the cycle after the response handshake.
- Latency: request accepted at edge N -> rsp_valid high after edge N+1. Minimum issue interval is 3 cycles with rsp_ready tied high.
- Requester contract: hold a, b and op stable while valid && !ready. The arbiter does not re-sample after acceptance, so later input changes do not affect the latched op.
- Dropping valid without ready is allowed; that requester is simply not considered.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- Arithmetic: the arbiter does no arithmetic; the result equals alu(a, b, op) at WORD_SIZE width, truncated, no carry out. EQUAL yields 1 or 0 in bit 0.
- Opcode encodings outside the defined set: the alu outputs 0, so rsp_data=0. This case is not flagged.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum logic [3:0] opcode_t {ADD, SUB, LEFT_SHIFT, RIGHT_SHIFT_ARITHMETIC, RIGHT_SHIFT_LOGIC, AND, OR, XOR, EQUAL}.
  - The FSM state typedef.
- Both alu and alu_arbiter import the package.
- One sub-module: alu, instantiated once with WORD_SIZE passed through.
- The round-robin pick is a function inside alu_arbiter, not a separate module.

Test Plan:
- Reset mid-transaction: assert rst while in EXEC -> rsp_valid=0 and busy=0 immediately. The next request from req1 (ADD 5,6) returns rsp_data=11 with rsp_id=1.
- Single requester: req2 ADD a=0x7FFF b=0x0001 -> req_ready[2] pulses 1 cycle; rsp_valid one edge later with rsp_data=0x8000, rsp_id=2. SUB 0x0000-0x0001 -> 0xFFFF.
- Round-robin: all 4 valid continuously with op=EQUAL a=b=i -> grant order 0,1,2,3,0; every rsp_data=1; rsp_id sequence matches.
- Back-pressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_data and rsp_id stable, all req_ready=0, busy=1. Release -> one handshake, then the next grant.
- Operand stability: change req_a[0] the cycle after acceptance -> result reflects the originally latched value (AND 0x0F0F,0x00FF -> 0x000F).
- Priority wrap: last_grant=3, requests only from 1 and 3 -> 1 is granted before 3.
